// File: rtl/mem_port_arbiter.sv
// Single-port BRAM arbiter: grants fetch or load/store one slot at a time,
// lays store data out in memory byte order and returns raw read words.
//
// state   | meaning
// IDLE    | port free; arbitrate and grant at most one requester this cycle
// WAIT    | multi-cycle read in flight; busy_q counts down to the response
module mem_port_arbiter #(
  parameter logic [31:0] CPU_BRAM_START = 32'h0000_0000,
  parameter logic [31:0] CPU_BRAM_END   = 32'h007F_FF00,
  parameter int          MEM_AW         = 21,
  parameter int          LAT            = 1,
  parameter int          STARVE_LIMIT   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [1:0]        d_memOp,
  input  logic [1:0]        d_memSize,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] MEM_DISABLE = 2'b00;
  localparam logic [1:0] MEM_WRITE   = 2'b11;
  localparam logic [1:0] BYTE        = 2'b00;
  localparam logic [1:0] HALFWORD    = 2'b01;
  localparam logic [1:0] WORD        = 2'b10;
  localparam int BW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] busy_q, busy_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          pend_fetch_q, pend_fetch_d;
  logic          pend_err_q, pend_err_d;
  logic          i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
  logic          d_done_q, d_done_d, d_err_q, d_err_d;
  logic [31:0]   i_hold_q, i_hold_d, d_hold_q, d_hold_d;

  logic          can_grant, fetch_pick, i_bad, d_bad;
  logic          fire, fire_fetch, fire_err;
  logic [3:0]    st_we;
  logic [31:0]   st_wdata;

  // Subtracting START first turns the window check into one unsigned compare.
  function automatic logic in_range(input logic [31:0] a);
    return (a - CPU_BRAM_START) < (CPU_BRAM_END - CPU_BRAM_START);
  endfunction

  always_comb begin
    can_grant  = (state_q == ST_IDLE) && !reset;
    fetch_pick = i_req && (!d_req || (starve_cnt_q == SW'(STARVE_LIMIT)));
    i_gnt      = can_grant && fetch_pick;
    d_gnt      = can_grant && d_req && !fetch_pick;
    i_bad      = (i_addr[1:0] != 2'b00) || !in_range(i_addr);
    d_bad      = !in_range(d_addr) || (d_memSize == 2'b11) ||
                 ((d_memSize == HALFWORD) && d_addr[0]) ||
                 ((d_memSize == WORD) && (d_addr[1:0] != 2'b00)) ||
                 (d_memOp == MEM_DISABLE);
  end

  // Byte offset k of the word lives in lane 3-k; value bytes fill upward from offset.
  always_comb begin
    st_we    = 4'b0000;
    st_wdata = 32'h0;
    case (d_memSize)
      BYTE: begin
        st_we    = 4'b1000 >> d_addr[1:0];
        st_wdata = {d_wdata[7:0], 24'h0} >> {d_addr[1:0], 3'b000};
      end
      HALFWORD: begin
        st_we    = d_addr[1] ? 4'b0011 : 4'b1100;
        st_wdata = {d_wdata[7:0], d_wdata[15:8], 16'h0} >> {d_addr[1], 4'b0000};
      end
      WORD: begin
        st_we    = 4'b1111;
        st_wdata = {d_wdata[7:0], d_wdata[15:8], d_wdata[23:16], d_wdata[31:24]};
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (i_gnt) begin
      mem_en   = !i_bad;
      mem_addr = i_addr[MEM_AW+1:2];
    end else if (d_gnt) begin
      mem_en   = !d_bad;
      mem_addr = d_addr[MEM_AW+1:2];
      if (!d_bad && (d_memOp == MEM_WRITE)) begin
        mem_we    = st_we;
        mem_wdata = st_wdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    starve_cnt_d = starve_cnt_q;
    pend_fetch_d = pend_fetch_q;
    pend_err_d   = pend_err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_gnt || d_gnt) begin
          pend_fetch_d = i_gnt;
          pend_err_d   = i_gnt ? i_bad : d_bad;
          if (LAT > 1) begin
            state_d = ST_WAIT;
            busy_d  = BW'(LAT - 1);
          end
        end
      end
      ST_WAIT: begin
        busy_d = busy_q - BW'(1);
        if (busy_q == BW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!i_req || i_gnt)
      starve_cnt_d = '0;
    else if (d_gnt && (starve_cnt_q != SW'(STARVE_LIMIT)))
      starve_cnt_d = starve_cnt_q + SW'(1);

    // Single-cycle reads answer straight from the grant; longer ones from the pending record.
    if (LAT == 1) begin
      fire       = i_gnt || d_gnt;
      fire_fetch = i_gnt;
      fire_err   = i_gnt ? i_bad : d_bad;
    end else begin
      fire       = (state_q == ST_WAIT) && (busy_q == BW'(1));
      fire_fetch = pend_fetch_q;
      fire_err   = pend_err_q;
    end
    i_rvalid_d = fire && fire_fetch;
    i_err_d    = fire && fire_fetch && fire_err;
    d_done_d   = fire && !fire_fetch;
    d_err_d    = fire && !fire_fetch && fire_err;
  end

  always_comb begin
    i_rvalid = i_rvalid_q;
    i_err    = i_err_q;
    d_done   = d_done_q;
    d_err    = d_err_q;
    i_rdata  = !i_rvalid_q ? i_hold_q : (i_err_q ? 32'h0 : mem_rdata);
    d_rdata  = !d_done_q ? d_hold_q : (d_err_q ? 32'h0 : mem_rdata);
    i_hold_d = i_rdata;
    d_hold_d = d_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= '0;
      starve_cnt_q <= '0;
      pend_fetch_q <= 1'b0;
      pend_err_q   <= 1'b0;
      i_rvalid_q   <= 1'b0;
      i_err_q      <= 1'b0;
      d_done_q     <= 1'b0;
      d_err_q      <= 1'b0;
      i_hold_q     <= 32'h0;
      d_hold_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      pend_fetch_q <= pend_fetch_d;
      pend_err_q   <= pend_err_d;
      i_rvalid_q   <= i_rvalid_d;
      i_err_q      <= i_err_d;
      d_done_q     <= d_done_d;
      d_err_q      <= d_err_d;
      i_hold_q     <= i_hold_d;
      d_hold_q     <= d_hold_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port arbiter and sequencer for the CPU block RAM, sitting between the instruction-fetch stage, the load/store stage and one BRAM port. Grants one requester per slot, with data priority and a fetch starvation guard. Drives BRAM address, write-enable lanes and little-endian write data, and returns raw read words with a fixed-latency valid strobe. Big-endian load shaping stays downstream; this block converts store data to memory byte order so a later load returns the stored value.

## Interface
- MEM_DISABLE / MEM_READ_SEXT / MEM_READ_ZEXT / MEM_WRITE, 2'b00/01/10/11: memOp encodings.
- BYTE / HALFWORD / WORD, 2'b00/01/10: memSize encodings (2'b11 illegal).
- CPU_BRAM_START, 32'h0000_0000: first legal byte address.
- CPU_BRAM_END, 32'h007F_FF00: legal iff START <= addr < END.
- MEM_AW, 21: BRAM word-address width.
- LAT, 1: BRAM read latency in cycles (>= 1).
- STARVE_LIMIT, 3: consecutive data grants tolerated while fetch waits.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- i_req  in  1  fetch request, held until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch response strobe.
- i_rdata  out  32  raw BRAM word.
- i_err  out  1  fetch rejected (qualifies i_rvalid).
- d_req  in  1  data request, held stable until d_gnt.
- d_addr  in  32  data byte address.
- d_memOp  in  2  operation.
- d_memSize  in  2  size.
- d_wdata  in  32  store value, right-justified.
- d_gnt  out  1  data accepted this cycle.
- d_done  out  1  data response strobe (loads and stores).
- d_rdata  out  32  raw BRAM word.
- d_err  out  1  data rejected (qualifies d_done).
- mem_en  out  1  BRAM port enable.
- mem_we  out  4  byte-lane write enables, bit k = bits [8k+7:8k].
- mem_addr  out  MEM_AW  word address = addr[MEM_AW+1:2].
- mem_wdata  out  32  write word.

## Operation
- States IDLE, WAIT. Grants only in IDLE. A grant in IDLE moves to WAIT when LAT > 1, with busy counter = LAT-1. WAIT decrements to 0, then returns to IDLE.
- Arbitration in IDLE: d_req wins unless starve_cnt == STARVE_LIMIT and i_req, in which case fetch wins.
- starve_cnt increments on each data grant made while i_req is high. It clears on a fetch grant or when i_req is low. It saturates at STARVE_LIMIT.
- Grant cycle: gnt, mem_en, mem_addr, mem_we and mem_wdata are combinational from the request. The response is registered.
- Fetch error: i_addr[1:0] != 0 or out of range.
- Data error: out of range, memSize = 2'b11, halfword with addr[0] = 1, word with addr[1:0] != 0, or d_memOp = MEM_DISABLE.
- Errored requests are granted with mem_en = 0 and mem_we = 0. Their response is rdata = 0 with err = 1.
- Loads (SEXT/ZEXT): mem_we = 0. Returned rdata is the raw word, unmodified.
- Store lanes: byte offset k → mem_we bit (3-k), that lane = wdata[7:0].
- Halfword offset 0 → we 4'b1100, [31:24] = wdata[7:0], [23:16] = wdata[15:8].
- Halfword offset 2 → we 4'b0011, [15:8] = wdata[7:0], [7:0] = wdata[15:8].
- Word → we 4'b1111, mem_wdata = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]}.
- Unwritten lanes of mem_wdata are 0.

## Timing
- Grant at cycle T. The rvalid/done/err strobe is high for exactly one cycle, at T+LAT. rdata is held until the next response.
- Back-to-back: at LAT = 1 the FSM is IDLE at T+1 and may grant again in the response cycle, giving one op per cycle. Otherwise the next grant is at the earliest T+LAT.
- At most one outstanding transaction. Only the granted side gets a response.
- Requests arriving while in WAIT are not granted until IDLE.
- Reset values: state IDLE, busy counter 0, starve_cnt 0, all strobes 0, rdata 0.
- While reset is high, gnt, mem_en and mem_we are forced 0.
- Reset mid-transaction drops the pending response. The requester re-requests.

## Test plan
- LAT=1: fetch at 0x0000_0010, BRAM word 0x1122_3344 → i_gnt at T, i_rvalid at T+1 with i_rdata 0x1122_3344, i_err = 0.
- Stores at 0x0000_0008: SB 0xAB at offset 1 → mem_we 0100, mem_wdata 0x00AB_0000. SH 0xBEEF at offset 2 → mem_we 0011, mem_wdata 0x0000_EFBE. SW 0x1234_5678 → mem_we 1111, mem_wdata 0x7856_3412.
- Continuous d_req and i_req, STARVE_LIMIT=3 → grant order D, D, D, I, D, D, D, I. No grant to either side in the same cycle.
- Errors: LH at 0x0000_0003, SW at 0x0100_0000, and fetch at 0x0000_0002 → gnt with mem_en = 0, then err strobe with rdata 0 at T+1. No BRAM write.
- LAT=3: two loads queued → grants at T and T+3, done at T+3 and T+6.
- Assert reset at T+1 with LAT=3 after a grant at T → no done at T+3, all outputs 0 during reset. First grant follows the first clk edge after reset deassertion.
